// File: rtl/cobs_stream_encoder.sv
// rtl/cobs_stream_encoder.sv - COBS byte-stream framer with 0x00 frame delimiter
//
// Purpose: buffers each run of up to 254 non-zero packet bytes, then emits the
// COBS code byte, the buffered bytes, an optional empty tail block and a
// terminating 0x00 delimiter (tlast=1) for every packet.
//
// Ports:
//   clk                  in   system clock
//   rst                  in   synchronous active-high reset
//   raw_stream_tdata     in   [7:0] unencoded packet byte
//   raw_stream_tvalid    in   raw byte valid
//   raw_stream_tready    out  raw byte accepted (only while filling a run)
//   raw_stream_tlast     in   last byte of packet
//   encoded_stream_tdata  out [7:0] COBS-encoded byte
//   encoded_stream_tvalid out encoded byte valid
//   encoded_stream_tready in  downstream ready
//   encoded_stream_tlast  out high only on the 0x00 delimiter

module cobs_stream_encoder #(
  parameter int MAX_RUN = 254
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_stream_tdata,
  input  logic       raw_stream_tvalid,
  output logic       raw_stream_tready,
  input  logic       raw_stream_tlast,
  output logic [7:0] encoded_stream_tdata,
  output logic       encoded_stream_tvalid,
  output logic       encoded_stream_tlast,
  input  logic       encoded_stream_tready
);

  localparam logic [7:0] RUN_FULL = 8'(MAX_RUN);

  typedef enum logic [2:0] {
    S_FILL,
    S_EMIT_CODE,
    S_EMIT_DATA,
    S_EMIT_TAIL,
    S_EMIT_DELIM
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [7:0] r_idx, w_idx;
  logic       r_pend_tail, w_pend_tail;  // run closed by a zero that carried tlast
  logic       r_eof, w_eof;              // delimiter follows the data of this run
  logic       r_in_ready, w_in_ready;
  logic       r_out_valid, w_out_valid;
  logic [7:0] r_out_data, w_out_data;
  logic       r_out_last, w_out_last;
  logic       w_wr_en;
  logic       w_in_beat;
  logic       w_out_beat;
  logic [7:0] w_cnt_inc;
  logic [7:0] r_buf [0:MAX_RUN-1];

  assign w_in_beat  = raw_stream_tvalid && r_in_ready;
  assign w_out_beat = r_out_valid && encoded_stream_tready;
  assign w_cnt_inc  = r_cnt + 8'd1;

  assign raw_stream_tready     = r_in_ready;
  assign encoded_stream_tvalid = r_out_valid;
  assign encoded_stream_tdata  = r_out_data;
  assign encoded_stream_tlast  = r_out_last;

  // Output register only advances when empty or when its beat is taken, so
  // tdata/tlast stay stable under back-pressure.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_pend_tail = r_pend_tail;
    w_eof       = r_eof;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_last  = r_out_last;
    w_wr_en     = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_in_beat) begin
          if (raw_stream_tdata == 8'h00) begin
            w_state     = S_EMIT_CODE;
            w_out_valid = 1'b1;
            w_out_data  = w_cnt_inc;
            w_pend_tail = raw_stream_tlast;
            w_eof       = 1'b0;
            w_idx       = 8'd0;
          end else begin
            w_wr_en = 1'b1;
            w_cnt   = w_cnt_inc;
            if (w_cnt_inc == RUN_FULL) begin
              // Full block: code 0xFF carries no implied zero.
              w_state     = S_EMIT_CODE;
              w_out_valid = 1'b1;
              w_out_data  = 8'hFF;
              w_pend_tail = 1'b0;
              w_eof       = raw_stream_tlast;
              w_idx       = 8'd0;
            end else if (raw_stream_tlast) begin
              w_state     = S_EMIT_CODE;
              w_out_valid = 1'b1;
              w_out_data  = w_cnt_inc + 8'd1;
              w_pend_tail = 1'b0;
              w_eof       = 1'b1;
              w_idx       = 8'd0;
            end
          end
        end
      end
      S_EMIT_CODE, S_EMIT_DATA: begin
        if (w_out_beat) begin
          if (r_idx < r_cnt) begin
            w_state    = S_EMIT_DATA;
            w_out_data = r_buf[r_idx];
            w_idx      = r_idx + 8'd1;
          end else if (r_pend_tail) begin
            // Packet ended on a zero: an empty block (0x01) encodes it.
            w_state    = S_EMIT_TAIL;
            w_out_data = 8'h01;
          end else if (r_eof) begin
            w_state    = S_EMIT_DELIM;
            w_out_data = 8'h00;
            w_out_last = 1'b1;
          end else begin
            w_state     = S_FILL;
            w_out_valid = 1'b0;
            w_out_data  = 8'h00;
            w_cnt       = 8'd0;
          end
        end
      end
      S_EMIT_TAIL: begin
        if (w_out_beat) begin
          w_state    = S_EMIT_DELIM;
          w_out_data = 8'h00;
          w_out_last = 1'b1;
        end
      end
      S_EMIT_DELIM: begin
        if (w_out_beat) begin
          w_state     = S_FILL;
          w_out_valid = 1'b0;
          w_out_data  = 8'h00;
          w_out_last  = 1'b0;
          w_cnt       = 8'd0;
          w_pend_tail = 1'b0;
          w_eof       = 1'b0;
        end
      end
      default: begin
        w_state     = S_FILL;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_cnt       = 8'd0;
      end
    endcase
    w_in_ready = (w_state == S_FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_cnt       <= 8'd0;
      r_idx       <= 8'd0;
      r_pend_tail <= 1'b0;
      r_eof       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_pend_tail <= w_pend_tail;
      r_eof       <= w_eof;
      r_in_ready  <= w_in_ready;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_last  <= w_out_last;
    end
  end

  // Run buffer has no reset; r_cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_buf[r_cnt] <= raw_stream_tdata;
    end
  end

endmodule

// File: tb/tb_cobs_stream_encoder.sv
// tb/tb_cobs_stream_encoder.sv - self-checking bench for cobs_stream_encoder

module tb_cobs_stream_encoder;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw_tdata = 8'h00;
  logic       raw_tvalid = 1'b0;
  logic       raw_tlast = 1'b0;
  logic       raw_tready;
  logic [7:0] enc_tdata;
  logic       enc_tvalid;
  logic       enc_tlast;
  logic       enc_tready = 1'b1;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;
  logic [8:0] rx_q[$];
  int frames_seen = 0;
  int frames_taken = 0;
  int last_stalls = 0;

  cobs_stream_encoder dut (
    .clk                   (clk),
    .rst                   (rst),
    .raw_stream_tdata      (raw_tdata),
    .raw_stream_tvalid     (raw_tvalid),
    .raw_stream_tready     (raw_tready),
    .raw_stream_tlast      (raw_tlast),
    .encoded_stream_tdata  (enc_tdata),
    .encoded_stream_tvalid (enc_tvalid),
    .encoded_stream_tlast  (enc_tlast),
    .encoded_stream_tready (enc_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      enc_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic       p_last = 1'b0;
  logic       p_rst = 1'b1;
  logic [7:0] p_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_while_emitting", 32'(raw_tready && enc_tvalid), 32'd0);
      if (p_valid && !p_ready && !p_rst) begin
        chk("stall_valid", 32'(enc_tvalid), 32'd1);
        chk("stall_data", 32'(enc_tdata), 32'(p_data));
        chk("stall_last", 32'(enc_tlast), 32'(p_last));
      end
      if (enc_tvalid && enc_tready) begin
        chk("zero_only_on_last", 32'(enc_tdata == 8'h00), 32'(enc_tlast));
        rx_q.push_back({enc_tlast, enc_tdata});
        if (enc_tlast) frames_seen++;
      end
    end
    p_valid <= enc_tvalid;
    p_ready <= enc_tready;
    p_data  <= enc_tdata;
    p_last  <= enc_tlast;
    p_rst   <= rst;
  end

  function automatic byte_q_t seg_enc(input byte_q_t s, input bit last);
    byte_q_t o;
    int full;
    int rem;
    full = s.size() / 254;
    rem  = s.size() % 254;
    for (int k = 0; k < full; k++) begin
      o.push_back(8'hFF);
      for (int j = 0; j < 254; j++) o.push_back(s[k*254 + j]);
    end
    if (!(last && full > 0 && rem == 0)) begin
      o.push_back(8'(rem + 1));
      for (int j = 0; j < rem; j++) o.push_back(s[full*254 + j]);
    end
    return o;
  endfunction

  function automatic byte_q_t cobs_ref(input byte_q_t p);
    byte_q_t o;
    byte_q_t seg;
    for (int i = 0; i < p.size(); i++) begin
      if (p[i] == 8'h00) begin
        o = {o, seg_enc(seg, 1'b0)};
        seg.delete();
      end else begin
        seg.push_back(p[i]);
      end
    end
    o = {o, seg_enc(seg, 1'b1)};
    o.push_back(8'h00);
    return o;
  endfunction

  function automatic byte_q_t cobs_dec(input byte_q_t e);
    byte_q_t o;
    int i;
    int n;
    int c;
    i = 0;
    n = e.size() - 1;
    while (i < n) begin
      c = int'(e[i]);
      if (c == 0) break;
      for (int j = 1; j < c; j++) if (i + j < n) o.push_back(e[i+j]);
      i += c;
      if (c != 255 && i < n) o.push_back(8'h00);
    end
    return o;
  endfunction

  function automatic bit q_eq(input byte_q_t a, input byte_q_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_packet(input byte_q_t p);
    int stalls;
    int t;
    stalls = 0;
    for (int i = 0; i < p.size(); i++) begin
      raw_tvalid = 1'b1;
      raw_tdata  = p[i];
      raw_tlast  = (i == p.size() - 1);
      t = 0;
      @(negedge clk);
      while (!raw_tready && t < 5000) begin
        t++;
        if (i > 0) stalls++;
        @(negedge clk);
      end
      if (!raw_tready) begin
        chk("input_accept_timeout", 32'(raw_tready), 32'd1);
        raw_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    raw_tvalid  = 1'b0;
    raw_tlast   = 1'b0;
    last_stalls = stalls;
  endtask

  task automatic get_frame(output byte_q_t f);
    int t;
    logic [8:0] e;
    t = 0;
    f = {};
    while (frames_seen == frames_taken && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("frame_timeout", 32'(frames_seen > frames_taken), 32'd1);
    if (frames_seen > frames_taken) begin
      do begin
        e = rx_q.pop_front();
        f.push_back(e[7:0]);
      end while (!e[8] && rx_q.size() > 0);
      frames_taken++;
    end
  endtask

  task automatic run_directed(input string tag, input byte_q_t p, input byte_q_t exp);
    byte_q_t f;
    send_packet(p);
    get_frame(f);
    chk({tag, "_len"}, 32'(f.size()), 32'(exp.size()));
    chk(tag, 32'(q_eq(f, exp)), 32'd1);
  endtask

  initial begin
    byte_q_t p;
    byte_q_t e;
    byte_q_t f;
    byte_q_t f2;
    int t;
    int s_a;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enc_tvalid", 32'(enc_tvalid), 32'd0);
    chk("reset_enc_tdata", 32'(enc_tdata), 32'h00);
    chk("reset_enc_tlast", 32'(enc_tlast), 32'd0);
    chk("reset_raw_tready", 32'(raw_tready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    p = '{8'h11, 8'h22};       e = '{8'h03, 8'h11, 8'h22, 8'h00};
    run_directed("pkt_11_22", p, e);
    p = '{8'h11, 8'h00, 8'h22}; e = '{8'h02, 8'h11, 8'h02, 8'h22, 8'h00};
    run_directed("pkt_11_00_22", p, e);
    p = '{8'h00};               e = '{8'h01, 8'h01, 8'h00};
    run_directed("pkt_00", p, e);
    p = '{8'h11, 8'h00};        e = '{8'h02, 8'h11, 8'h01, 8'h00};
    run_directed("pkt_11_00", p, e);

    p = {}; e = '{8'hFF};
    for (int i = 1; i <= 254; i++) begin p.push_back(8'(i)); e.push_back(8'(i)); end
    e.push_back(8'h00);
    run_directed("pkt_254", p, e);

    p = {}; e = '{8'hFF};
    for (int i = 1; i <= 255; i++) p.push_back(8'(i));
    for (int i = 1; i <= 254; i++) e.push_back(8'(i));
    e.push_back(8'h02); e.push_back(8'hFF); e.push_back(8'h00);
    run_directed("pkt_255", p, e);

    // back-to-back packets with tvalid kept high
    p = '{8'h01, 8'h02, 8'h03};
    send_packet(p);
    s_a = last_stalls;
    p = '{8'h00, 8'h05};
    send_packet(p);
    get_frame(f);
    get_frame(f2);
    chk("fill_throughput_stalls", 32'(s_a), 32'd0);
    e = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h00};
    chk("b2b_frame_a", 32'(q_eq(f, e)), 32'd1);
    e = '{8'h01, 8'h02, 8'h05, 8'h00};
    chk("b2b_frame_b", 32'(q_eq(f2, e)), 32'd1);

    // random packets against the reference encoder and decoder
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int len;
      len = $urandom_range(1, 600);
      p = {};
      for (int i = 0; i < len; i++)
        p.push_back(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send_packet(p);
      get_frame(f);
      chk("rand_encode", 32'(q_eq(f, cobs_ref(p))), 32'd1);
      chk("rand_decode", 32'(q_eq(cobs_dec(f), p)), 32'd1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset in the middle of emitting a 100-byte run
    p = {};
    for (int i = 0; i < 100; i++) p.push_back(8'($urandom_range(1, 255)));
    send_packet(p);
    t = 0;
    while (rx_q.size() < 50 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("abort_midrun_reached", 32'(rx_q.size() >= 50), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_enc_tvalid", 32'(enc_tvalid), 32'd0);
    chk("abort_raw_tready", 32'(raw_tready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rx_q.delete();
    frames_taken = frames_seen;
    p = '{8'hAA};               e = '{8'h02, 8'hAA, 8'h00};
    run_directed("after_abort", p, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
